detector_arbiter: RTL
=====================

# detector_arbiter

Two-requester arbiter and sequencer for the team's 2-bit serial sequence-detector FSM, which has one clock, a synchronous bit input x, a Moore output z, and an asynchronous active-high reset.
- Each requester presents a W-bit word. The block grants one requester, clears the detector, and streams the word MSB-first into it.
- It counts the bits after which the detector reports a hit (z==0), then returns the count with a one-cycle done pulse.
- It sits between the requesters and a single shared detector instance, and is the only driver of that detector's reset and x inputs.

## Interface
- W, 8, word width in bits; W >= 2
- CW, 4, hit-counter width; must satisfy 2^CW > W
- clk  input  1  clock; all state changes on posedge
- r  input  1  asynchronous, active-low reset
- req0, req1  input  1 each  request levels; data must stay stable while req is high and gnt has not yet pulsed
- data0, data1  input  W each  word of requester 0 / 1
- gnt0, gnt1  output  1 each  one-cycle grant pulse; the word was captured at the edge that raised it
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle result-valid pulse
- done_id  output  1  requester whose word produced the current hits
- hits  output  CW  hit count of the last completed word; held until the next done
- det_r  output  1  active-high reset to the detector
- det_x  output  1  serial bit to the detector
- det_z  input  1  detector output; 0 = hit

## Operation
- All outputs are registered.
- Reset values (r low): state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, hits=0, det_r=1, det_x=0, rr pointer=0 (requester 0 preferred next).
- IDLE
  - det_r=1, det_x=0.
  - If any req is high, arbitrate, capture the winner's data into the shift register, pulse the winner's gnt, load bitcnt=0, and go to SHIFT.
  - If only one req is high, it wins.
  - If both are high, the pointer side wins; the pointer then moves to the other requester.
- SHIFT
  - det_r=0; det_x = shift-register MSB.
  - Each edge shifts left by one and increments bitcnt.
  - After W cycles, go to DRAIN.
- DRAIN: det_x=0; one cycle; go to DONE.
- DONE
  - done=1 for one cycle; hits and done_id are final.
  - Go to IDLE. The new hits value is cleared internally and accumulated in a separate counter; the hits output updates only when done rises.
- Hit counting: at each edge where state is SHIFT with bitcnt >= 1, or state is DRAIN, and det_z==0, increment the accumulator.
  - This samples z after each of the W bits.
  - The z value seen on the first SHIFT edge reflects the cleared detector and is not counted.
  - The accumulator saturates at 2^CW-1 (unreachable when the CW rule holds).
- req activity during busy is ignored; no queuing. A req still high when the block returns to IDLE is arbitrated normally.
- Requester 0 at bit-level: word 0x00 gives hits=3, 0xFF gives 0, 0x80 gives 2, 0x3F gives 7.

## Timing
- Edge e0 (IDLE, req seen): the winner's gnt is high during cycle e0..e1; det_x carries bit W-1 in that same cycle.
- Bit i (MSB=0) is on det_x during cycle e_i..e_(i+1); the detector consumes it at edge e_(i+1).
- done is high during cycle e_(W+1)..e_(W+2). That is W+1 cycles after gnt: 9 for W=8.
- The earliest next gnt is at edge e_(W+2), so the period is W+2 cycles per word.
- r low mid-operation:
  - Immediately return to IDLE with reset values; det_r=1.
  - No done is produced for the aborted word, and hits returns to 0.

## Configuration
- DETARB_FIXED_PRIO_EN
  - Defined: fixed priority; requester 0 always wins a tie and the rr pointer is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold r=0 with random inputs -> gnt0=gnt1=0, busy=0, done=0, hits=0, det_r=1, det_x=0 throughout.
- Single request: req0=1, data0=0x00 -> gnt0 pulses; det_x=0 for 8 cycles; done 9 cycles after gnt0 with hits=3, done_id=0; busy high from the gnt edge through the done cycle.
- Patterns: req1 with data1=0x80 -> hits=2, done_id=1; then req0 with 0x3F -> hits=7; then req0 with 0xFF -> hits=0.
- Contention: req0 and req1 both held high, data0=0xFF, data1=0x3F:
  - Default build: grants alternate 0,1,0,1; hits alternate 0,7; gnt edges 10 cycles apart.
  - With DETARB_FIXED_PRIO_EN: gnt0 every 10 cycles, gnt1 never.
- Busy ignore: raise req1 during the SHIFT of requester 0's word and hold it -> no gnt1 until state reaches IDLE; gnt1 arrives exactly 10 cycles after gnt0.
- Abort: drop r for 1 ns during the 4th SHIFT cycle -> busy=0 and det_r=1 at once; no done; hits=0. The next req1 alone is granted normally and completes with the correct hits.

Source files
------------

// File: rtl/detector_arbiter_if.sv
// detector_arbiter_if
//   Bundles the requester handshake and the shared-detector connection of
//   detector_arbiter.
//   Parameters: W  word width in bits, CW  hit-counter width.
//   Requester side: req0/req1 request levels, data0/data1 words,
//     gnt0/gnt1 one-cycle grant pulses, busy, done pulse, done_id, hits.
//   Detector side: det_r active-high detector reset, det_x serial bit,
//     det_z detector output (0 = hit).
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus detector).
`timescale 1ns/1ps
interface detector_arbiter_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          req0;
  logic          req1;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic          gnt0;
  logic          gnt1;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [CW-1:0] hits;
  logic          det_r;
  logic          det_x;
  logic          det_z;

  modport slave (
    input  req0, req1, data0, data1, det_z,
    output gnt0, gnt1, busy, done, done_id, hits, det_r, det_x
  );

  modport master (
    output req0, req1, data0, data1, det_z,
    input  gnt0, gnt1, busy, done, done_id, hits, det_r, det_x
  );
endinterface

// File: rtl/detector_arbiter.sv
// detector_arbiter
//   Grants one of two requesters, clears the shared serial sequence
//   detector, streams the granted W-bit word into it MSB-first and counts
//   the bits after which the detector reports a hit (det_z == 0). The count
//   is returned on hits with a one-cycle done pulse; one word takes W+2
//   cycles from grant to the earliest next grant.
//   Ports:
//     clk  clock, all state changes on the rising edge
//     r    asynchronous active-low reset
//     bus  detector_arbiter_if.slave (requester handshake + detector pins)
//   Configuration macro:
//     DETARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie and no
//                           round-robin pointer exists.
//                           undefined (default): round-robin on ties.
`timescale 1ns/1ps
module detector_arbiter #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                r,
  detector_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] ACC_MAX  = '1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_t        state_q;
  logic [W-1:0]  shreg_q;
  logic [CW-1:0] bitcnt_q;
  logic [CW-1:0] acc_q;
  logic [CW-1:0] hits_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          done_q;
  logic          done_id_q;
  logic          owner_q;
  logic          det_r_q;
  logic          det_x_q;

  // Arbitration: win_id is the requester that would be granted this edge.
  logic          any_req;
  logic          win_id;
  logic [W-1:0]  win_data;

  assign any_req = bus.req0 | bus.req1;

`ifdef DETARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is asking.
  assign win_id = ~bus.req0;
`else
  logic rr_q;  // requester preferred on the next tie

  assign win_id = (bus.req0 && bus.req1) ? rr_q : bus.req1;

  // The pointer moves only when a tie is actually resolved.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      rr_q <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && bus.req0 && bus.req1) begin
      rr_q <= ~rr_q;
    end
  end
`endif

  assign win_data = win_id ? bus.data1 : bus.data0;

  // A hit is sampled after each streamed bit: SHIFT edges from the second
  // one on (the first sees the freshly cleared detector), plus the DRAIN
  // edge that sees the response to the last bit.
  logic          hit_sample;
  logic [CW-1:0] acc_d;

  assign hit_sample = ((state_q == SHIFT && bitcnt_q != '0) || state_q == DRAIN)
                      && !bus.det_z;
  assign acc_d      = (hit_sample && acc_q != ACC_MAX) ? acc_q + 1'b1 : acc_q;

  // NOTE: every register here, the shift register included, is reset and
  // updated only with non-blocking assignments so all state advances
  // together on the edge and an abort leaves no stale word behind.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      acc_q     <= '0;
      hits_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      owner_q   <= 1'b0;
      det_r_q   <= 1'b1;
      det_x_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        // DONE doubles as an arbitration slot so back-to-back words keep a
        // W+2 cycle period; det_r was raised on entry to DONE, so the
        // detector is already cleared when the next word starts.
        IDLE, DONE: begin
          acc_q   <= '0;
          det_r_q <= 1'b1;
          det_x_q <= 1'b0;
          state_q <= IDLE;
          if (any_req) begin
            state_q  <= SHIFT;
            owner_q  <= win_id;
            gnt0_q   <= ~win_id;
            gnt1_q   <= win_id;
            det_r_q  <= 1'b0;
            // The MSB goes out in the grant cycle; the register keeps the
            // remaining bits already aligned to its MSB.
            det_x_q  <= win_data[W-1];
            shreg_q  <= win_data << 1;
            bitcnt_q <= '0;
          end
        end
        SHIFT: begin
          acc_q    <= acc_d;
          det_x_q  <= shreg_q[W-1];
          shreg_q  <= shreg_q << 1;
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            state_q <= DRAIN;
            det_x_q <= 1'b0;
          end
        end
        DRAIN: begin
          acc_q     <= acc_d;
          hits_q    <= acc_d;
          done_q    <= 1'b1;
          done_id_q <= owner_q;
          det_r_q   <= 1'b1;
          det_x_q   <= 1'b0;
          state_q   <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.hits    = hits_q;
  assign bus.det_r   = det_r_q;
  assign bus.det_x   = det_x_q;

endmodule
